// File: rtl/gbf_load_pkg.sv
// -----------------------------------------------------------------------------
// gbf_load_pkg
// Shared definitions for the TS3D global-buffer load sequencer:
//   - tgt_e   : write-port selector carried in the header word
//   - state_e : sequencer state encoding
//   - header field bit positions and widths
//   - isWeiSide() helper to pick the address width family of a target
// No ports; imported by gbf_load_addrgen and gbf_load_ctrl.
// -----------------------------------------------------------------------------
package gbf_load_pkg;

    typedef enum logic [1:0] {
        TGT_WEI    = 2'd0,
        TGT_FLGWEI = 2'd1,
        TGT_ACT    = 2'd2,
        TGT_FLGACT = 2'd3
    } tgt_e;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    localparam int HDR_TGT_LSB  = 0;
    localparam int HDR_TGT_MSB  = 1;
    localparam int HDR_ADDR_LSB = 2;
    localparam int HDR_ADDR_MSB = 17;
    localparam int HDR_LEN_LSB  = 18;
    localparam int HDR_LEN_MSB  = 31;
    localparam int HDR_ADDR_W   = HDR_ADDR_MSB - HDR_ADDR_LSB + 1;
    localparam int HDR_LEN_W    = HDR_LEN_MSB - HDR_LEN_LSB + 1;

    // Bits that must be zero in a FLGACT header; reserved for future targets.
    localparam int HDR_RSV_LSB  = 62;
    localparam int HDR_RSV_MSB  = 63;

    // Weight and weight-flag buffers share the WEI address width,
    // activation and activation-flag buffers share the ACT width.
    function automatic logic isWeiSide(input tgt_e tgt);
        return (tgt == TGT_WEI) || (tgt == TGT_FLGWEI);
    endfunction

endpackage

// File: rtl/gbf_load_addrgen.sv
// -----------------------------------------------------------------------------
// gbf_load_addrgen
// Loadable wrapping address counter plus burst down-counter.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   i_load                : load start address and remaining count
//   i_loadAddr [AW-1:0]   : start address (masked by i_mask on load)
//   i_loadCnt  [CW-1:0]   : remaining words after the first (LEN-1)
//   i_step                : one word written; advance address, count down
//   i_mask     [AW-1:0]   : all-ones over the active address width, so the
//                           address wraps modulo 2^(target AW)
//   o_addr     [AW-1:0]   : address for the next write
//   o_last                : the next write is the last of the burst
// -----------------------------------------------------------------------------
module gbf_load_addrgen
    import gbf_load_pkg::*;
#(
    parameter int AW = 12,
    parameter int CW = HDR_LEN_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [AW-1:0] i_loadAddr,
    input  logic [CW-1:0] i_loadCnt,
    input  logic          i_step,
    input  logic [AW-1:0] i_mask,
    output logic [AW-1:0] o_addr,
    output logic          o_last
);

    logic [AW-1:0] r_addr;
    logic [CW-1:0] r_cnt;

    // Load has priority over step; the two are mutually exclusive in the
    // controller anyway. The count floors at zero so a stray step after
    // the last word cannot underflow into a huge burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_addr <= i_loadAddr & i_mask;
            r_cnt  <= i_loadCnt;
        end else if (i_step) begin
            r_addr <= (r_addr + AW'(1)) & i_mask;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_cnt == '0);

endmodule

// File: rtl/gbf_load_ctrl.sv
// -----------------------------------------------------------------------------
// gbf_load_ctrl
// Load sequencer for the TS3D global buffers. A valid/ready word stream is
// parsed as header + LEN payload words; payloads are written, one per
// accepted beat, to the WEI / FLGWEI / ACT / FLGACT global-buffer ports with
// an incrementing, wrapping address.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   IF_Dat/IF_Val/IF_Rdy          : input word stream
//   GBF*_Val                      : target buffer can accept a write
//   GBF*_EnWr/_AddrWr/_DatWr      : registered write port per buffer
//   Busy                          : burst in progress
//   Done                          : one-cycle pulse with the final write
//   Err                           : sticky, FLGACT header with bits 63:62 set
//   StallCnt [15:0]               : only when GBF_LOAD_STALLCNT_EN is defined;
//                                   saturating count of target-stall cycles
// Build option: define GBF_LOAD_STALLCNT_EN to add the StallCnt port.
// -----------------------------------------------------------------------------
module gbf_load_ctrl
    import gbf_load_pkg::*;
#(
    parameter int PORT_DW   = 64,
    parameter int WEI_AW    = 12,
    parameter int ACT_AW    = 12,
    parameter int WEI_DW    = 64,
    parameter int FLGWEI_DW = 32,
    parameter int ACT_DW    = 8,
    parameter int FLGACT_DW = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PORT_DW-1:0]   IF_Dat,
    input  logic                 IF_Val,
    output logic                 IF_Rdy,
    input  logic                 GBFWEI_Val,
    input  logic                 GBFFLGWEI_Val,
    input  logic                 GBFACT_Val,
    input  logic                 GBFFLGACT_Val,
    output logic                 GBFWEI_EnWr,
    output logic                 GBFFLGWEI_EnWr,
    output logic                 GBFACT_EnWr,
    output logic                 GBFFLGACT_EnWr,
    output logic [WEI_AW-1:0]    GBFWEI_AddrWr,
    output logic [WEI_AW-1:0]    GBFFLGWEI_AddrWr,
    output logic [ACT_AW-1:0]    GBFACT_AddrWr,
    output logic [ACT_AW-1:0]    GBFFLGACT_AddrWr,
    output logic [WEI_DW-1:0]    GBFWEI_DatWr,
    output logic [FLGWEI_DW-1:0] GBFFLGWEI_DatWr,
    output logic [ACT_DW-1:0]    GBFACT_DatWr,
    output logic [FLGACT_DW-1:0] GBFFLGACT_DatWr,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Err
`ifdef GBF_LOAD_STALLCNT_EN
    ,
    output logic [15:0]          StallCnt
`endif
);

    localparam int AW = (WEI_AW > ACT_AW) ? WEI_AW : ACT_AW;
    localparam logic [AW-1:0] WEI_MASK = AW'((64'd1 << WEI_AW) - 64'd1);
    localparam logic [AW-1:0] ACT_MASK = AW'((64'd1 << ACT_AW) - 64'd1);

    state_e                r_state;
    tgt_e                  r_tgt;
    logic                  r_live;
    logic                  w_tgtVal;
    logic                  w_accept;
    logic                  w_last;
    logic [AW-1:0]         w_addr;
    logic [AW-1:0]         w_mask;
    tgt_e                  w_hdrTgt;
    logic [AW-1:0]         w_hdrAddr;
    logic [HDR_LEN_W-1:0]  w_hdrCnt;
    logic [1:0]            w_rsvBits;

    assign w_hdrTgt  = tgt_e'(IF_Dat[HDR_TGT_MSB:HDR_TGT_LSB]);
    assign w_hdrAddr = AW'(IF_Dat[HDR_ADDR_MSB:HDR_ADDR_LSB]);
    assign w_hdrCnt  = IF_Dat[HDR_LEN_MSB:HDR_LEN_LSB];

    generate
        if (PORT_DW > HDR_RSV_MSB) begin : g_rsvBits
            assign w_rsvBits = IF_Dat[HDR_RSV_MSB:HDR_RSV_LSB];
        end else begin : g_noRsvBits
            assign w_rsvBits = 2'b00;
        end
    endgenerate

    // Val of the latched target gates the stream during a burst; the other
    // three Val inputs have no effect.
    always_comb begin
        w_tgtVal = 1'b0;
        case (r_tgt)
            TGT_WEI:    w_tgtVal = GBFWEI_Val;
            TGT_FLGWEI: w_tgtVal = GBFFLGWEI_Val;
            TGT_ACT:    w_tgtVal = GBFACT_Val;
            TGT_FLGACT: w_tgtVal = GBFFLGACT_Val;
            default:    w_tgtVal = 1'b0;
        endcase
    end

    // r_live keeps IF_Rdy low until the first clock after reset release.
    assign IF_Rdy   = r_live & ((r_state == IDLE) | w_tgtVal);
    assign w_accept = IF_Val & IF_Rdy;

    // The header picks the wrap width on load; the latched target on steps.
    assign w_mask = (r_state == IDLE)
                  ? (isWeiSide(w_hdrTgt) ? WEI_MASK : ACT_MASK)
                  : (isWeiSide(r_tgt)    ? WEI_MASK : ACT_MASK);

    gbf_load_addrgen #(
        .AW (AW),
        .CW (HDR_LEN_W)
    ) u_addrgen (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     ((r_state == IDLE) & w_accept),
        .i_loadAddr (w_hdrAddr),
        .i_loadCnt  (w_hdrCnt),
        .i_step     ((r_state == BURST) & w_accept),
        .i_mask     (w_mask),
        .o_addr     (w_addr),
        .o_last     (w_last)
    );

    // Sequencer with all outputs registered. In IDLE an accepted beat is a
    // header; in BURST each accepted beat becomes one write on the latched
    // target. The last write returns to IDLE so the next header can be
    // taken in the same cycle that Done is high. Address/data of ports not
    // being written keep their previous value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_tgt            <= TGT_WEI;
            r_live           <= 1'b0;
            GBFWEI_EnWr      <= 1'b0;
            GBFFLGWEI_EnWr   <= 1'b0;
            GBFACT_EnWr      <= 1'b0;
            GBFFLGACT_EnWr   <= 1'b0;
            GBFWEI_AddrWr    <= '0;
            GBFFLGWEI_AddrWr <= '0;
            GBFACT_AddrWr    <= '0;
            GBFFLGACT_AddrWr <= '0;
            GBFWEI_DatWr     <= '0;
            GBFFLGWEI_DatWr  <= '0;
            GBFACT_DatWr     <= '0;
            GBFFLGACT_DatWr  <= '0;
            Busy             <= 1'b0;
            Done             <= 1'b0;
            Err              <= 1'b0;
        end else begin
            r_live         <= 1'b1;
            GBFWEI_EnWr    <= 1'b0;
            GBFFLGWEI_EnWr <= 1'b0;
            GBFACT_EnWr    <= 1'b0;
            GBFFLGACT_EnWr <= 1'b0;
            Done           <= 1'b0;
            case (r_state)
                IDLE: begin
                    Busy <= w_accept;
                    if (w_accept) begin
                        r_tgt   <= w_hdrTgt;
                        r_state <= BURST;
                        if ((w_hdrTgt == TGT_FLGACT) && (w_rsvBits != 2'b00)) begin
                            Err <= 1'b1;
                        end
                    end
                end
                BURST: begin
                    Busy <= 1'b1;
                    if (w_accept) begin
                        case (r_tgt)
                            TGT_WEI: begin
                                GBFWEI_EnWr   <= 1'b1;
                                GBFWEI_AddrWr <= WEI_AW'(w_addr);
                                GBFWEI_DatWr  <= IF_Dat[WEI_DW-1:0];
                            end
                            TGT_FLGWEI: begin
                                GBFFLGWEI_EnWr   <= 1'b1;
                                GBFFLGWEI_AddrWr <= WEI_AW'(w_addr);
                                GBFFLGWEI_DatWr  <= IF_Dat[FLGWEI_DW-1:0];
                            end
                            TGT_ACT: begin
                                GBFACT_EnWr   <= 1'b1;
                                GBFACT_AddrWr <= ACT_AW'(w_addr);
                                GBFACT_DatWr  <= IF_Dat[ACT_DW-1:0];
                            end
                            default: begin
                                GBFFLGACT_EnWr   <= 1'b1;
                                GBFFLGACT_AddrWr <= ACT_AW'(w_addr);
                                GBFFLGACT_DatWr  <= IF_Dat[FLGACT_DW-1:0];
                            end
                        endcase
                        if (w_last) begin
                            Done    <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef GBF_LOAD_STALLCNT_EN
    // Counts burst cycles where the host offers a word but the target
    // buffer holds it off; restarts with each new header and saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCnt <= '0;
        end else if ((r_state == IDLE) && w_accept) begin
            StallCnt <= '0;
        end else if ((r_state == BURST) && IF_Val && !w_tgtVal && (StallCnt != 16'hFFFF)) begin
            StallCnt <= StallCnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gbf_load_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_gbf_load_ctrl
// Self-checking bench for gbf_load_ctrl: a table of directed bursts, a few
// hand-written multi-cycle sequences and randomized bursts, all compared each
// cycle against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_gbf_load_ctrl;

   localparam int PORT_DW = 64, WEI_AW = 12, ACT_AW = 12;
   localparam int WEI_DW = 64, FLGWEI_DW = 32, ACT_DW = 8, FLGACT_DW = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [63:0] IF_Dat = '0;
   logic IF_Val = 1'b0;
   logic IF_Rdy;
   logic tv [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
   logic GBFWEI_EnWr, GBFFLGWEI_EnWr, GBFACT_EnWr, GBFFLGACT_EnWr;
   logic [WEI_AW-1:0] GBFWEI_AddrWr, GBFFLGWEI_AddrWr;
   logic [ACT_AW-1:0] GBFACT_AddrWr, GBFFLGACT_AddrWr;
   logic [WEI_DW-1:0] GBFWEI_DatWr;
   logic [FLGWEI_DW-1:0] GBFFLGWEI_DatWr;
   logic [ACT_DW-1:0] GBFACT_DatWr;
   logic [FLGACT_DW-1:0] GBFFLGACT_DatWr;
   logic Busy, Done, Err;
`ifdef GBF_LOAD_STALLCNT_EN
   logic [15:0] StallCnt;
`endif

   gbf_load_ctrl #(
      .PORT_DW(PORT_DW), .WEI_AW(WEI_AW), .ACT_AW(ACT_AW), .WEI_DW(WEI_DW),
      .FLGWEI_DW(FLGWEI_DW), .ACT_DW(ACT_DW), .FLGACT_DW(FLGACT_DW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .IF_Dat(IF_Dat), .IF_Val(IF_Val), .IF_Rdy(IF_Rdy),
      .GBFWEI_Val(tv[0]), .GBFFLGWEI_Val(tv[1]), .GBFACT_Val(tv[2]), .GBFFLGACT_Val(tv[3]),
      .GBFWEI_EnWr(GBFWEI_EnWr), .GBFFLGWEI_EnWr(GBFFLGWEI_EnWr),
      .GBFACT_EnWr(GBFACT_EnWr), .GBFFLGACT_EnWr(GBFFLGACT_EnWr),
      .GBFWEI_AddrWr(GBFWEI_AddrWr), .GBFFLGWEI_AddrWr(GBFFLGWEI_AddrWr),
      .GBFACT_AddrWr(GBFACT_AddrWr), .GBFFLGACT_AddrWr(GBFFLGACT_AddrWr),
      .GBFWEI_DatWr(GBFWEI_DatWr), .GBFFLGWEI_DatWr(GBFFLGWEI_DatWr),
      .GBFACT_DatWr(GBFACT_DatWr), .GBFFLGACT_DatWr(GBFFLGACT_DatWr),
      .Busy(Busy), .Done(Done), .Err(Err)
`ifdef GBF_LOAD_STALLCNT_EN
      , .StallCnt(StallCnt)
`endif
   );

   always #5 clk = ~clk;

   int nCmp = 0;
   int nFail = 0;
   int cyc = 0;

   // Reference model: burst described by start, length and beat index.
   int mPhase, mTgt, mStart, mLen, mIdx, mStall;
   bit mLive;
   int expEn;
   bit expDone, expBusy, expErr;
   logic [63:0] expAddr [4];
   logic [63:0] expDat [4];
   int lastHdrAccCyc;

   // What the DUT was seen doing, for the directed timing checks.
   int obsCnt [4], obsFirstAddr [4], obsLastAddr [4], obsFirstCyc [4], obsLastCyc [4];
   int obsDoneCyc, obsDoneCnt;

   function automatic logic [63:0] dmask(input int t);
      case (t)
         0: return 64'hFFFF_FFFF_FFFF_FFFF;
         2: return 64'h0000_0000_0000_00FF;
         default: return 64'h0000_0000_FFFF_FFFF;
      endcase
   endfunction

   function automatic int awOf(input int t);
      return (t < 2) ? WEI_AW : ACT_AW;
   endfunction

   function automatic logic [63:0] hdr(input int t, input int addr, input int len, input logic [1:0] rsv);
      logic [63:0] h;
      h = '0;
      h[1:0] = 2'(t);
      h[17:2] = 16'(addr);
      h[31:18] = 14'(len - 1);
      h[63:62] = rsv;
      return h;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nCmp++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic modelReset();
      mPhase = 0; mTgt = 0; mStart = 0; mLen = 0; mIdx = 0; mStall = 0;
      mLive = 0; expEn = -1; expDone = 0; expBusy = 0; expErr = 0;
      for (int p = 0; p < 4; p++) begin
         expAddr[p] = '0;
         expDat[p] = '0;
      end
   endtask

   task automatic clearObs();
      for (int p = 0; p < 4; p++) begin
         obsCnt[p] = 0; obsFirstAddr[p] = -1; obsLastAddr[p] = -1;
         obsFirstCyc[p] = -1; obsLastCyc[p] = -1;
      end
      obsDoneCyc = -1;
      obsDoneCnt = 0;
   endtask

   // Compare every output against the model and note observed writes.
   task automatic checkOutput();
      logic [3:0] en;
      logic [3:0] expEnV;
      logic [63:0] a [4];
      logic [63:0] d [4];
      bit expRdy;
      en = {GBFFLGACT_EnWr, GBFACT_EnWr, GBFFLGWEI_EnWr, GBFWEI_EnWr};
      a[0] = 64'(GBFWEI_AddrWr); a[1] = 64'(GBFFLGWEI_AddrWr);
      a[2] = 64'(GBFACT_AddrWr); a[3] = 64'(GBFFLGACT_AddrWr);
      d[0] = 64'(GBFWEI_DatWr); d[1] = 64'(GBFFLGWEI_DatWr);
      d[2] = 64'(GBFACT_DatWr); d[3] = 64'(GBFFLGACT_DatWr);
      expEnV = (expEn >= 0) ? 4'(1 << expEn) : 4'b0000;
      expRdy = mLive && ((mPhase == 0) || tv[mTgt]);
      check("EnWr", 64'(en), 64'(expEnV));
      for (int p = 0; p < 4; p++) begin
         check($sformatf("AddrWr[%0d]", p), a[p], expAddr[p]);
         check($sformatf("DatWr[%0d]", p), d[p], expDat[p]);
      end
      check("IF_Rdy", 64'(IF_Rdy), 64'(expRdy));
      check("Done", 64'(Done), 64'(expDone));
      check("Busy", 64'(Busy), 64'(expBusy));
      check("Err", 64'(Err), 64'(expErr));
`ifdef GBF_LOAD_STALLCNT_EN
      check("StallCnt", 64'(StallCnt), 64'(mStall));
`endif
      for (int p = 0; p < 4; p++) begin
         if (en[p]) begin
            if (obsCnt[p] == 0) begin
               obsFirstAddr[p] = int'(a[p]);
               obsFirstCyc[p] = cyc;
            end
            obsLastAddr[p] = int'(a[p]);
            obsLastCyc[p] = cyc;
            obsCnt[p]++;
         end
      end
      if (Done) begin
         if (obsDoneCyc < 0) obsDoneCyc = cyc;
         obsDoneCnt++;
      end
   endtask

   // Model update at a rising edge, given whether a beat was accepted.
   task automatic modelEdge(input bit acc, input bit stallNow);
      if (!rst_n) return;
      mLive = 1;
      expEn = -1;
      expDone = 0;
      if (acc && mPhase == 0) begin
         mTgt = int'(IF_Dat[1:0]);
         mStart = int'(IF_Dat[17:2]);
         mLen = int'(IF_Dat[31:18]) + 1;
         mIdx = 0;
         mPhase = 1;
         expBusy = 1;
         mStall = 0;
         if (mTgt == 3 && IF_Dat[63:62] != 2'b00) expErr = 1;
      end else if (acc) begin
         expEn = mTgt;
         expAddr[mTgt] = 64'((mStart + mIdx) % (1 << awOf(mTgt)));
         expDat[mTgt] = IF_Dat & dmask(mTgt);
         mIdx++;
         expBusy = 1;
         if (mIdx == mLen) begin
            expDone = 1;
            mPhase = 0;
         end
      end else begin
         expBusy = (mPhase == 1);
         if (stallNow && mStall < 65535) mStall++;
      end
   endtask

   // One clock: check at the falling edge, advance the model at the rising.
   task automatic tick();
      bit acc, stallNow;
      @(negedge clk);
      cyc++;
      checkOutput();
      acc = IF_Val && mLive && ((mPhase == 0) || tv[mTgt]);
      stallNow = (mPhase == 1) && IF_Val && !tv[mTgt];
      if (acc && mPhase == 0) lastHdrAccCyc = cyc;
      @(posedge clk);
      modelEdge(acc, stallNow);
      #1;
   endtask

   // Offer one word until it is accepted; rnd adds valid gaps and target stalls.
   task automatic applyStimulus(input logic [63:0] w, input bit rnd);
      bit taken;
      int budget;
      taken = 0;
      budget = 0;
      while (!taken) begin
         if (budget > 300) begin
            nCmp++;
            nFail++;
            $display("[TB] FAIL handshake timeout: word 0x%0h not accepted in %0d cycles", w, budget);
            IF_Val = 1'b0;
            return;
         end
         if (rnd) begin
            IF_Val = ($urandom_range(0, 3) != 0);
            for (int p = 0; p < 4; p++) tv[p] = ($urandom_range(0, 3) != 0);
         end else begin
            IF_Val = 1'b1;
         end
         IF_Dat = IF_Val ? w : {$urandom, $urandom};
         taken = IF_Val && mLive && ((mPhase == 0) || tv[mTgt]);
         tick();
         budget++;
      end
      IF_Val = 1'b0;
   endtask

   task automatic sendBurst(input int t, input int addr, input int len, input logic [1:0] rsv, input bit rnd);
      applyStimulus(hdr(t, addr, len, rsv), rnd);
      for (int i = 0; i < len; i++) applyStimulus({$urandom, $urandom}, rnd);
   endtask

   task automatic idle(input int n);
      IF_Val = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   typedef struct {
      int tgt; int addr; int len; int offVal;
      int expFirst; int expLast; int expCnt; int expSpan;
   } vec_t;

   vec_t vecs [6];

   initial begin
      #1_500_000;
      $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int hdrCyc;
      vecs[0] = '{0, 'h010, 4, -1, 'h010, 'h013, 4, 3};
      vecs[1] = '{2, 'hFFE, 4, -1, 'hFFE, 'h001, 4, 3};
      vecs[2] = '{1, 'hFFFF, 3, -1, 'hFFF, 'h001, 3, 2};
      vecs[3] = '{3, 'h123, 1, -1, 'h123, 'h123, 1, 0};
      vecs[4] = '{2, 'h7F0, 16, 0, 'h7F0, 'h7FF, 16, 15};
      vecs[5] = '{0, 'h000, 16384, -1, 'h000, 'hFFF, 16384, 16383};

      // Reset state, then release.
      modelReset();
      clearObs();
      idle(3);
      rst_n = 1'b1;
      idle(2);

      // Directed bursts from the table.
      for (int v = 0; v < 6; v++) begin
         for (int p = 0; p < 4; p++) tv[p] = 1'b1;
         if (vecs[v].offVal >= 0) tv[vecs[v].offVal] = 1'b0;
         clearObs();
         sendBurst(vecs[v].tgt, vecs[v].addr, vecs[v].len, 2'b00, 0);
         idle(2);
         check($sformatf("vec%0d first addr", v), 64'(obsFirstAddr[vecs[v].tgt]), 64'(vecs[v].expFirst));
         check($sformatf("vec%0d last addr", v), 64'(obsLastAddr[vecs[v].tgt]), 64'(vecs[v].expLast));
         check($sformatf("vec%0d write count", v), 64'(obsCnt[vecs[v].tgt]), 64'(vecs[v].expCnt));
         check($sformatf("vec%0d write span", v),
               64'(obsLastCyc[vecs[v].tgt] - obsFirstCyc[vecs[v].tgt]), 64'(vecs[v].expSpan));
         check($sformatf("vec%0d other writes", v),
               64'(obsCnt[0] + obsCnt[1] + obsCnt[2] + obsCnt[3] - obsCnt[vecs[v].tgt]), 64'(0));
         check($sformatf("vec%0d done pulses", v), 64'(obsDoneCnt), 64'(1));
         check($sformatf("vec%0d done with last write", v),
               64'(obsDoneCyc), 64'(obsLastCyc[vecs[v].tgt]));
      end
      for (int p = 0; p < 4; p++) tv[p] = 1'b1;

      // FLGACT burst with the target held off for 3 cycles after beat 2.
      clearObs();
      applyStimulus(hdr(3, 'h200, 8, 2'b00), 0);
      applyStimulus({$urandom, $urandom}, 0);
      applyStimulus({$urandom, $urandom}, 0);
      tv[3] = 1'b0;
      IF_Val = 1'b1;
      IF_Dat = {$urandom, $urandom};
      for (int i = 0; i < 3; i++) tick();
      tv[3] = 1'b1;
      for (int i = 0; i < 6; i++) applyStimulus({$urandom, $urandom}, 0);
      idle(2);
      check("stall write count", 64'(obsCnt[3]), 64'(8));
      check("stall write span", 64'(obsLastCyc[3] - obsFirstCyc[3]), 64'(10));
      check("stall last addr", 64'(obsLastAddr[3]), 64'('h207));
`ifdef GBF_LOAD_STALLCNT_EN
      check("stall count", 64'(StallCnt), 64'(3));
`endif

      // Back-to-back: FLGWEI LEN 1, then a WEI header with no gap.
      clearObs();
      sendBurst(1, 'h040, 1, 2'b00, 0);
      applyStimulus(hdr(0, 'h080, 2, 2'b00), 0);
      hdrCyc = lastHdrAccCyc;
      applyStimulus({$urandom, $urandom}, 0);
      applyStimulus({$urandom, $urandom}, 0);
      idle(2);
      check("b2b header with done", 64'(hdrCyc), 64'(obsDoneCyc));
      check("b2b first write delay", 64'(obsFirstCyc[0] - obsDoneCyc), 64'(2));
      check("b2b first addr", 64'(obsFirstAddr[0]), 64'('h080));

      // Reserved header bits only flag an error for FLGACT.
      sendBurst(0, 'h011, 1, 2'b11, 0);
      idle(1);
      check("err not for WEI", 64'(Err), 64'(0));
      sendBurst(3, 'h011, 1, 2'b10, 0);
      idle(1);
      check("err for FLGACT", 64'(Err), 64'(1));

      // Reset after 5 of 10 ACT writes.
      applyStimulus(hdr(2, 'h300, 10, 2'b00), 0);
      for (int i = 0; i < 5; i++) applyStimulus({$urandom, $urandom}, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst Rdy", 64'(IF_Rdy), 64'(0));
      check("rst ACT EnWr", 64'(GBFACT_EnWr), 64'(0));
      check("rst ACT AddrWr", 64'(GBFACT_AddrWr), 64'(0));
      check("rst Busy", 64'(Busy), 64'(0));
      check("rst Err", 64'(Err), 64'(0));
      modelReset();
      idle(2);
      rst_n = 1'b1;
      idle(1);
      clearObs();
      sendBurst(0, 'h050, 2, 2'b00, 0);
      idle(2);
      check("post-rst no ACT writes", 64'(obsCnt[2]), 64'(0));
      check("post-rst WEI first addr", 64'(obsFirstAddr[0]), 64'('h050));
      check("post-rst WEI count", 64'(obsCnt[0]), 64'(2));

      // Randomized bursts with valid gaps and target stalls.
      for (int b = 0; b < 60; b++) begin
         sendBurst($urandom_range(0, 3), int'($urandom_range(0, 16'hFFFF)),
                   $urandom_range(1, 12), 2'($urandom_range(0, 3)), 1);
         IF_Val = 1'b0;
         idle($urandom_range(0, 2));
      end
      for (int p = 0; p < 4; p++) tv[p] = 1'b1;
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

endmodule
